// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: samples a framed serial stream (start bit, DATA_W data
// bits MSB-first, optional even-parity bit, stop bit) and delivers each good
// word to parallel logic over a valid/ready handshake. It also reports framing
// errors, parity errors and dropped words.
// Optional feature macro: SERIAL_FRAME_PARITY_EN adds a PARITY state between
// DATA and STOP. When the macro is not defined, parity_err is tied to 0.
module serial_frame_receiver #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    input  logic              out_ready,
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overflow,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CW-1:0]     bit_cnt;

`ifdef SERIAL_FRAME_PARITY_EN
    logic par_bad;    // latched parity mismatch of the frame in flight
    logic par_pulse;
    assign parity_err = par_pulse;
`else
    assign parity_err = 1'b0;
`endif

    // Frame FSM with registered handshake, error pulses and the sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
            par_bad   <= 1'b0;
            par_pulse <= 1'b0;
`endif
        end else begin
            // The error pulses last one cycle. A word accepted with no new
            // load frees the holding register.
            frame_err <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
            par_pulse <= 1'b0;
`endif
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            // A drop in the STOP branch below overrides this clear.
            if (clr_ovf)
                overflow <= 1'b0;

            case (state)
                IDLE: begin
                    if (serial_in) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                DATA: begin
                    shreg   <= {shreg[DATA_W-2:0], serial_in};
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_FRAME_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                    end
                end
`ifdef SERIAL_FRAME_PARITY_EN
                PARITY: begin
                    // Even parity: the data bits and the parity bit together hold an even number of 1s.
                    par_bad <= ^{shreg, serial_in};
                    state   <= STOP;
                end
`endif
                STOP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (serial_in)
                        frame_err <= 1'b1;
`ifdef SERIAL_FRAME_PARITY_EN
                    else if (par_bad)
                        par_pulse <= 1'b1;
`endif
                    else if (!out_valid || out_ready) begin
                        data_out  <= shreg;
                        out_valid <= 1'b1;
                    end else
                        overflow <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Testbench for serial_frame_receiver (DATA_W=4). The bench builds frames, so
// it knows which edge carries the stop bit of each frame. A frame-level model
// (holding register, sticky overflow, error pulses) predicts every output
// after every clock edge.
module tb_serial_frame_receiver;

    localparam int DW = 4;
`ifdef SERIAL_FRAME_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          serial_in = 1'b0;
    logic          out_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [DW-1:0] data_out;
    logic          out_valid, frame_err, parity_err, overflow, busy;

    serial_frame_receiver #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .out_ready(out_ready),
        .clr_ovf(clr_ovf), .data_out(data_out), .out_valid(out_valid),
        .frame_err(frame_err), .parity_err(parity_err), .overflow(overflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit rnd_ctl = 1'b0;

    // model state
    logic [DW-1:0] m_data;
    logic m_valid, m_ovf, m_ferr, m_perr, m_busy;

    typedef struct {
        logic [DW-1:0] word;
        logic          stop;
        logic          rdy;
        logic          rdy_stop;
        int            gap;
        logic [DW-1:0] exp_data;
        logic          exp_valid;
        logic          exp_ferr;
        logic          exp_ovf;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_data = '0; m_valid = 0; m_ovf = 0; m_ferr = 0; m_perr = 0; m_busy = 0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".data_out"},   16'(data_out),   16'(m_data));
        chk({tag, ".out_valid"},  16'(out_valid),  16'(m_valid));
        chk({tag, ".frame_err"},  16'(frame_err),  16'(m_ferr));
        chk({tag, ".parity_err"}, 16'(parity_err), 16'(m_perr));
        chk({tag, ".overflow"},   16'(overflow),   16'(m_ovf));
        chk({tag, ".busy"},       16'(busy),       16'(m_busy));
    endtask

    // kind: 0 idle bit, 1 in-frame bit (not stop), 2 good stop, 3 stop=1, 4 parity-bad stop
    task automatic step(input logic sin, input logic rdy, input logic clr, input int kind,
                        input logic [DW-1:0] w);
        bit drop = 0;
        m_ferr = (kind == 3);
        m_perr = (kind == 4);
        m_busy = (kind == 1);
        if (kind == 2) begin
            if (!m_valid || rdy) begin
                m_data = w; m_valid = 1;
            end else drop = 1;
        end else if (m_valid && rdy) m_valid = 0;
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
        serial_in = sin; out_ready = rdy; clr_ovf = clr;
        @(posedge clk);
        #1;
        chk_all("cyc");
    endtask

    function automatic logic pick_rdy(input logic r);
        return rnd_ctl ? logic'($urandom_range(0, 1)) : r;
    endfunction

    function automatic logic pick_clr();
        return rnd_ctl ? ($urandom_range(0, 7) == 0) : 1'b0;
    endfunction

    task automatic send_frame(input logic [DW-1:0] w, input logic stop, input bit par_ok,
                              input logic rdy, input logic rdy_stop);
        int ks;
        step(1'b1, pick_rdy(rdy), pick_clr(), 1, w);
        for (int i = DW - 1; i >= 0; i--) step(w[i], pick_rdy(rdy), pick_clr(), 1, w);
        if (PAR) step((^w) ^ !par_ok, pick_rdy(rdy), pick_clr(), 1, w);
        ks = stop ? 3 : (PAR && !par_ok) ? 4 : 2;
        step(stop, pick_rdy(rdy_stop), pick_clr(), ks, w);
    endtask

    task automatic gap_cycles(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, pick_rdy(rdy), pick_clr(), 0, '0);
    endtask

    initial begin
        //          word     stop rdy rdyS gap exp_data exp_v ferr ovf
        vt[0] = '{4'b1011, 0, 1, 1, 2, 4'b1011, 1, 0, 0};
        vt[1] = '{4'b0110, 1, 1, 1, 0, 4'b1011, 0, 1, 0};
        vt[2] = '{4'b1001, 0, 1, 1, 2, 4'b1001, 1, 0, 0};
        vt[3] = '{4'b1011, 0, 0, 0, 0, 4'b1011, 1, 0, 0};
        vt[4] = '{4'b0101, 0, 0, 0, 1, 4'b1011, 1, 0, 1};
        vt[5] = '{4'b1011, 0, 0, 0, 0, 4'b1011, 1, 0, 0};
        vt[6] = '{4'b0101, 0, 0, 1, 1, 4'b0101, 1, 0, 0};

        // reset state
        model_reset();
        #2;
        chk_all("reset");
        @(negedge clk);
        rst = 1'b1;
        gap_cycles(2, 1'b0);

        for (int v = 0; v < 7; v++) begin
            send_frame(vt[v].word, vt[v].stop, 1'b1, vt[v].rdy, vt[v].rdy_stop);
            chk($sformatf("vec%0d.data_out", v), 16'(data_out), 16'(vt[v].exp_data));
            chk($sformatf("vec%0d.out_valid", v), 16'(out_valid), 16'(vt[v].exp_valid));
            chk($sformatf("vec%0d.frame_err", v), 16'(frame_err), 16'(vt[v].exp_ferr));
            chk($sformatf("vec%0d.overflow", v), 16'(overflow), 16'(vt[v].exp_ovf));
            gap_cycles(vt[v].gap, vt[v].rdy);
            if (v == 4) begin
                // accept the held word, then clear the sticky overflow flag
                step(1'b0, 1'b1, 1'b0, 0, '0);
                chk("accept.out_valid", 16'(out_valid), 16'd0);
                chk("accept.overflow", 16'(overflow), 16'd1);
                step(1'b0, 1'b0, 1'b1, 0, '0);
                chk("clr_ovf.overflow", 16'(overflow), 16'd0);
            end
        end
        step(1'b0, 1'b1, 1'b0, 0, '0);

        // reset asserted after two data bits of a frame
        step(1'b1, 1'b0, 1'b0, 1, '0);
        step(1'b1, 1'b0, 1'b0, 1, '0);
        step(1'b0, 1'b0, 1'b0, 1, '0);
        rst = 1'b0;
        model_reset();
        #2;
        chk_all("midrst");
        @(negedge clk);
        rst = 1'b1;
        gap_cycles(1, 1'b1);
        send_frame(4'b1100, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("after_rst.data_out", 16'(data_out), 16'hC);
        chk("after_rst.out_valid", 16'(out_valid), 16'd1);
        gap_cycles(1, 1'b1);

`ifdef SERIAL_FRAME_PARITY_EN
        send_frame(4'b1011, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("par_ok.data_out", 16'(data_out), 16'hB);
        chk("par_ok.out_valid", 16'(out_valid), 16'd1);
        gap_cycles(1, 1'b1);
        send_frame(4'b1011, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("par_bad.parity_err", 16'(parity_err), 16'd1);
        chk("par_bad.out_valid", 16'(out_valid), 16'd0);
        gap_cycles(2, 1'b1);
`endif

        // random frames, gaps, ready and clear
        rnd_ctl = 1'b1;
        for (int f = 0; f < 80; f++) begin
            send_frame(DW'($urandom), ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 4) != 0), 1'b0, 1'b0);
            gap_cycles($urandom_range(0, 3), 1'b0);
        end
        rnd_ctl = 1'b0;
        gap_cycles(2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
